// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-split helpers for the data cache.
// The address is split into {tag, index, offset}; the offset is 5 bits
// (32-byte line of eight 32-bit words) and the word select is offset[4:2].
package dcache_pkg;

  localparam int LINE_NUM_DEF = 32;
  localparam int LINE_W_DEF   = 256;
  localparam int ADDR_W_DEF   = 32;

  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int WSEL_LSB = 2;
  localparam int WSEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dc_state_e;

  // Number of index bits for a given number of lines.
  function automatic int index_w(input int line_num);
    return $clog2(line_num);
  endfunction

  // Tag is whatever is left above index and line offset.
  function automatic int tag_w(input int addr_w, input int line_num);
    return addr_w - index_w(line_num) - OFFSET_W;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: MEM-stage port and line-wide memory port of the data cache.
// The slave modport is the cache controller; master is its environment.
interface dcache_if
  import dcache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);
  logic [ADDR_W-1:0] p1_addr_i;
  logic [WORD_W-1:0] p1_data_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [WORD_W-1:0] p1_data_o;
  logic              p1_stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data storage for the direct-mapped cache.
// Asynchronous read, one synchronous write port that either fills a whole
// line (refill) or merges a single word (store hit). Valid/dirty clear
// asynchronously on reset; tag and data contents are don't-care until valid.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINE_NUM = LINE_NUM_DEF,
  parameter int LINE_W   = LINE_W_DEF,
  parameter int TAG_W    = tag_w(ADDR_W_DEF, LINE_NUM_DEF),
  parameter int IDX_W    = index_w(LINE_NUM)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              we_i,
  input  logic              fill_i,
  input  logic [WSEL_W-1:0] wsel_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic [TAG_W-1:0]  tag_i
);

  logic [TAG_W-1:0]    tag_q   [LINE_NUM];
  logic [LINE_W-1:0]   data_q  [LINE_NUM];
  logic [LINE_NUM-1:0] valid_q;
  logic [LINE_NUM-1:0] dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_q[idx_i];

  // Data/tag write: whole line on refill, single word merge on store hit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (fill_i) begin
        data_q[idx_i] <= line_i;
        tag_q[idx_i]  <= tag_i;
      end else begin
        data_q[idx_i][{wsel_i, 5'b00000} +: WORD_W] <= word_i;
      end
    end
  end

  // Valid/dirty bookkeeping; a refill leaves the line clean, a store dirties it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      if (fill_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end else begin
        dirty_q[idx_i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally; a miss stalls the MEM stage while the
// dirty victim is written back and the requested line is refilled, after
// which the access replays as a hit.
// Optional build macro DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_NUM = LINE_NUM_DEF,
  parameter int LINE_W   = LINE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int IDX_W = index_w(LINE_NUM);
  localparam int TAG_W = tag_w(ADDR_W, LINE_NUM);

  dc_state_e         state_q, state_d;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;

  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [WSEL_W-1:0] wsel_s;
  logic [IDX_W-1:0]  idx_s;
  logic              req_s, in_idle_s, hit_s, stall_s, miss_start_s, we_s, fill_s;
  logic [TAG_W-1:0]  tag_s;
  logic              valid_s, dirty_s;
  logic [LINE_W-1:0] line_s;
  logic              mem_en_s, mem_wr_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [LINE_W-1:0] mem_data_s;
  logic              unused_s;

  assign req_tag_s = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx_s = bus.p1_addr_i[OFFSET_W +: IDX_W];
  assign wsel_s    = bus.p1_addr_i[WSEL_LSB +: WSEL_W];
  assign unused_s  = &{1'b0, bus.p1_addr_i[WSEL_LSB-1:0]};

  assign req_s     = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign in_idle_s = (state_q == ST_IDLE);
  // During a miss the array is addressed by the latched miss index so the
  // transaction is unaffected if the MEM stage drops its request.
  assign idx_s     = in_idle_s ? req_idx_s : miss_idx_q;

  assign hit_s   = rst_i & req_s & in_idle_s & valid_s & (tag_s == req_tag_s);
  assign stall_s = rst_i & ((req_s & ~hit_s) | ~in_idle_s);
  assign miss_start_s = in_idle_s & (state_d != ST_IDLE);

  // Store hits merge a word; a refill ack writes the whole line.
  assign fill_s = (state_q == ST_REFILL);
  assign we_s   = (hit_s & bus.p1_MemWrite_i) | (fill_s & bus.mem_ack_i);

  dcache_sram #(
    .LINE_NUM (LINE_NUM),
    .LINE_W   (LINE_W),
    .TAG_W    (TAG_W),
    .IDX_W    (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx_i   (idx_s),
    .tag_o   (tag_s),
    .valid_o (valid_s),
    .dirty_o (dirty_s),
    .line_o  (line_s),
    .we_i    (we_s),
    .fill_i  (fill_s),
    .wsel_i  (wsel_s),
    .word_i  (bus.p1_data_i),
    .line_i  (bus.mem_data_i),
    .tag_i   (miss_tag_q)
  );

  assign bus.p1_stall_o   = stall_s;
  assign bus.p1_data_o    = hit_s ? line_s[{wsel_s, 5'b00000} +: WORD_W] : {WORD_W{1'b0}};
  assign bus.mem_enable_o = mem_en_s;
  assign bus.mem_write_o  = mem_wr_s;
  assign bus.mem_addr_o   = mem_addr_s;
  assign bus.mem_data_o   = mem_data_s;

  // FSM state register; reset aborts any transaction at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory-port outputs; fields are stable for a whole state.
  always_comb begin
    state_d    = state_q;
    mem_en_s   = 1'b0;
    mem_wr_s   = 1'b0;
    mem_addr_s = '0;
    mem_data_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && !hit_s) begin
          if (valid_s && dirty_s) state_d = ST_WRITEBACK;
          else                    state_d = ST_REFILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        mem_en_s   = 1'b1;
        mem_wr_s   = 1'b1;
        mem_addr_s = {tag_s, miss_idx_q, OFFSET_W'(0)};
        mem_data_s = line_s;
        if (bus.mem_ack_i) state_d = ST_REFILL;
        else               state_d = ST_WRITEBACK;
      end
      ST_REFILL: begin
        mem_en_s   = 1'b1;
        mem_addr_s = {miss_tag_q, miss_idx_q, OFFSET_W'(0)};
        if (bus.mem_ack_i) state_d = ST_IDLE;
        else               state_d = ST_REFILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the missing line's tag/index when a miss is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else if (miss_start_s) begin
      miss_tag_q <= req_tag_s;
      miss_idx_q <= req_idx_s;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Free-running hit/miss counters; a miss also counts its replay hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (hit_s && !stall_s) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start_s)      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage and a multi-cycle, line-wide data memory. The MEM stage issues word reads and writes. The controller serves hits in the same cycle and stalls the pipeline on a miss. During a miss it writes back the dirty victim line, then refills the requested line.

## Interface
Parameters:
- LINE_NUM, 32, number of cache lines (power of two).
- LINE_W, 256, line width in bits (8 words).
- ADDR_W, 32, byte-address width.

Ports:
- clk_i, in, 1, clock, rising edge.
- rst_i, in, 1, reset, asynchronous, active-low.
- p1_addr_i, in, ADDR_W, byte address from MEM stage.
- p1_data_i, in, 32, store data.
- p1_MemRead_i, in, 1, load request.
- p1_MemWrite_i, in, 1, store request.
- p1_data_o, out, 32, load data, valid when request and not stalled.
- p1_stall_o, out, 1, pipeline stall.
- mem_addr_o, out, ADDR_W, line-aligned memory address.
- mem_data_o, out, LINE_W, write-back line data.
- mem_enable_o, out, 1, memory request.
- mem_write_o, out, 1, 1 = write-back, 0 = refill.
- mem_data_i, in, LINE_W, refill data, valid with mem_ack_i.
- mem_ack_i, in, 1, one-cycle completion pulse.

## Operation
- Address split with defaults:
  - offset [4:0]; word select [4:2].
  - index [4+log2(LINE_NUM):5].
  - tag is the remaining upper bits (22 bits by default).
- Request: req = p1_MemRead_i | p1_MemWrite_i. Both high is treated as a write.
- Hit: req & valid[index] & tag match & state==IDLE.
- Read hit:
  - p1_data_o = selected word, combinational.
  - p1_stall_o = 0.
- Write hit:
  - Selected word updated at the clock edge; dirty set; p1_stall_o = 0.
- p1_stall_o = req & ~hit. It is combinational and is also asserted in every non-IDLE state.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE: on req & ~hit, go to WRITEBACK if the victim is valid & dirty, else go to REFILL.
  - WRITEBACK:
    - Outputs: mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
    - On mem_ack_i, go to REFILL.
  - REFILL:
    - Outputs: mem_enable_o = 1, mem_write_o = 0.
    - mem_addr_o = {req tag, index, 5'b0}.
    - On mem_ack_i: write mem_data_i into the line, set valid = 1, dirty = 0, update the tag, go to IDLE.
- After a refill, the access is replayed in IDLE as a hit. A write hit then merges the store and sets dirty.
- Memory handshake: the request fields stay constant from entry into the state until the mem_ack_i cycle inclusive. mem_enable_o drops in the cycle after the ack.
- The MEM stage holds p1_* stable while stalled. If req drops mid-miss, the transaction still completes, the line is filled and the FSM returns to IDLE.
- mem_ack_i in IDLE is ignored.

## Timing
- Hit latency: 0 cycles (combinational read data; the write commits at the edge).
- Miss, clean victim: stall for (memory latency + 1) cycles. For a memory acking N cycles after enable: N+2 stall cycles including the replay-detect cycle.
- Miss, dirty victim: two memory transactions back to back, with no idle cycle between WRITEBACK ack and REFILL enable.
- Reset values (while rst_i low and after release):
  - State IDLE; all valid/dirty bits 0.
  - mem_enable_o = 0, mem_write_o = 0.
  - mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0.
  - p1_stall_o forced 0 while rst_i low.
- Reset mid-transaction aborts immediately. mem_enable_o falls asynchronously and the partial line is discarded.

## Configuration
- DCACHE_STATS_EN defined: adds ports hit_cnt_o (out, 32) and miss_cnt_o (out, 32).
  - Both reset to 0 and wrap at 2^32.
  - miss_cnt_o increments on each IDLE->WRITEBACK/REFILL transition.
  - hit_cnt_o increments each cycle with hit & ~stall. A missed access therefore counts one miss plus one hit (the replay).
- DCACHE_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - FSM state enum.
  - OFFSET_W, INDEX_W, TAG_W derivation.
  - Line-address helper constants.
- Sub-module dcache_sram:
  - Tag, valid, dirty and data arrays.
  - Asynchronous read, single synchronous write port.
  - Line write with per-word merge for store hits.
  - Async active-low clear of valid/dirty.
- dcache_ctrl holds the FSM, hit logic, word mux and memory interface.

## Test plan
- Cold read of 0x0000_0040 with memory acking 10 cycles after enable:
  - REFILL with mem_addr_o = 0x40, mem_write_o = 0.
  - Stall deasserts on the replay cycle; p1_data_o = word 0 of the returned line.
- Store 0xDEADBEEF to 0x44, then load 0x44:
  - Both are hits after the first refill.
  - The load returns 0xDEADBEEF; dirty[2] = 1; no memory traffic.
- Load 0x0000_0444 (same index 2, different tag) after the dirty store:
  - WRITEBACK with mem_addr_o = 0x40 carrying 0xDEADBEEF in word 1.
  - REFILL of 0x440 follows with no idle cycle.
- p1_MemRead_i and p1_MemWrite_i high together on a hit: the store is performed and the data is written.
- Assert rst_i low during REFILL before the ack:
  - mem_enable_o goes to 0 immediately and all lines become invalid.
  - After release, the same load misses again.
- With DCACHE_STATS_EN: 1 cold miss followed by 3 hits to the same line gives miss_cnt_o = 1 and hit_cnt_o = 4.
